hqm_rf_2048x14_arb_init: RTL and testbench

//  Controller for one 2048x14 two-port power-gated RF.
//  - After reset, or on request, sequences a full-array initialisation to INIT_VAL.
//  - Then shares the RF between two write requesters and two read requesters with

---
 rtl/hqm_rf_2048x14_arb_init.sv | 165 ++++++++++++++++
 tb/tb_hqm_rf_2048x14_arb_init.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hqm_rf_2048x14_arb_init.sv
// hqm_rf_2048x14_arb_init
//   Controller for one 2048x14 two-port RF. After reset (or on cfg_reinit)
//   it writes INIT_VAL to every entry, then shares the RF between two write
//   and two read requesters through independent round-robin arbiters.
//   Read responses are tagged with the requester index; a read that
//   collides with a same-cycle write to the same address returns the
//   forwarded write data.
// Ports
//   rclk, rclk_rst_n            clock (also RF clock), async active-low reset
//   cfg_reinit                  restart array init (READY only)
//   init_busy, init_done        init in progress / sticky first-init-complete
//   wr_req_v/addr/data/rdy      two write requesters, {req1,req0} packing
//   rd_req_v/addr/rdy           two read requesters, {req1,req0} packing
//   rd_rsp_v/id/data            read response, two cycles after accept
//   mem_we/waddr/wdata          RF write port (registered)
//   mem_re/raddr                RF read port (registered)
//   mem_rdata                   RF read data, one cycle after mem_re
module hqm_rf_2048x14_arb_init #(
    parameter int unsigned    DEPTH    = 2048,
    parameter int unsigned    AW       = 11,
    parameter int unsigned    DW       = 14,
    parameter logic [DW-1:0]  INIT_VAL = '0
) (
    input  logic              rclk,
    input  logic              rclk_rst_n,
    input  logic              cfg_reinit,
    output logic              init_busy,
    output logic              init_done,
    input  logic [1:0]        wr_req_v,
    input  logic [2*AW-1:0]   wr_req_addr,
    input  logic [2*DW-1:0]   wr_req_data,
    output logic [1:0]        wr_req_rdy,
    input  logic [1:0]        rd_req_v,
    input  logic [2*AW-1:0]   rd_req_addr,
    output logic [1:0]        rd_req_rdy,
    output logic              rd_rsp_v,
    output logic              rd_rsp_id,
    output logic [DW-1:0]     rd_rsp_data,
    output logic              mem_we,
    output logic [AW-1:0]     mem_waddr,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_re,
    output logic [AW-1:0]     mem_raddr,
    input  logic [DW-1:0]     mem_rdata
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic            wr_ptr;
    logic            rd_ptr;

    // Read pipeline: stage 1 aligns with mem_re, stage 2 with rd_rsp_v.
    logic            rd_id1;
    logic            byp_hit1;
    logic [DW-1:0]   byp_data1;
    logic            byp_hit2;
    logic [DW-1:0]   byp_data2;

    logic            arb_en;
    logic            wr_acc;
    logic            wr_sel;
    logic [AW-1:0]   wr_addr_sel;
    logic [DW-1:0]   wr_data_sel;
    logic            rd_acc;
    logic            rd_sel;
    logic [AW-1:0]   rd_addr_sel;

    // ptr names the requester favoured when both are valid.
    function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic ptr);
        logic [1:0] g;
        case (v)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = ptr ? 2'b10 : 2'b01;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    always_comb begin
        arb_en      = (state == ST_READY) && !cfg_reinit;
        wr_req_rdy  = arb_en ? rr_pick(wr_req_v, wr_ptr) : 2'b00;
        rd_req_rdy  = arb_en ? rr_pick(rd_req_v, rd_ptr) : 2'b00;
        wr_acc      = |wr_req_rdy;
        wr_sel      = wr_req_rdy[1];
        rd_acc      = |rd_req_rdy;
        rd_sel      = rd_req_rdy[1];
        wr_addr_sel = wr_sel ? wr_req_addr[2*AW-1:AW] : wr_req_addr[AW-1:0];
        wr_data_sel = wr_sel ? wr_req_data[2*DW-1:DW] : wr_req_data[DW-1:0];
        rd_addr_sel = rd_sel ? rd_req_addr[2*AW-1:AW] : rd_req_addr[AW-1:0];
    end

    assign init_busy = (state == ST_INIT);

    // A same-cycle write to the read address lands in the RF on the same edge
    // the RF samples the read, so the RF returns stale data; forward instead.
    assign rd_rsp_data = !rd_rsp_v ? '0 : (byp_hit2 ? byp_data2 : mem_rdata);

    always_ff @(posedge rclk or negedge rclk_rst_n) begin
        if (!rclk_rst_n) begin
            state     <= ST_INIT;
            cnt       <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            init_done <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_raddr <= '0;
            rd_id1    <= 1'b0;
            byp_hit1  <= 1'b0;
            byp_data1 <= '0;
            byp_hit2  <= 1'b0;
            byp_data2 <= '0;
            rd_rsp_v  <= 1'b0;
            rd_rsp_id <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    mem_we    <= 1'b1;
                    mem_waddr <= cnt;
                    mem_wdata <= INIT_VAL;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    mem_we <= wr_acc;
                    if (wr_acc) begin
                        mem_waddr <= wr_addr_sel;
                        mem_wdata <= wr_data_sel;
                    end
                    if (cfg_reinit) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
            endcase

            if (wr_acc) wr_ptr <= ~wr_sel;
            if (rd_acc) rd_ptr <= ~rd_sel;

            // The read pipeline keeps running across a reinit so in-flight
            // reads still complete.
            mem_re <= rd_acc;
            if (rd_acc) mem_raddr <= rd_addr_sel;
            rd_id1    <= rd_sel;
            byp_hit1  <= wr_acc && rd_acc && (wr_addr_sel == rd_addr_sel);
            byp_data1 <= wr_data_sel;

            rd_rsp_v  <= mem_re;
            rd_rsp_id <= rd_id1;
            byp_hit2  <= byp_hit1;
            byp_data2 <= byp_data1;
        end
    end

endmodule

// File: tb/tb_hqm_rf_2048x14_arb_init.sv
// tb_hqm_rf_2048x14_arb_init
//   Directed bench for hqm_rf_2048x14_arb_init with a behavioural 2048x14 RF
//   (one-cycle read latency, read-before-write on same-edge collision).
module tb_hqm_rf_2048x14_arb_init;

    localparam int AW = 11;
    localparam int DW = 14;

    logic              rclk = 1'b0;
    logic              rclk_rst_n;
    logic              cfg_reinit;
    logic              init_busy;
    logic              init_done;
    logic [1:0]        wr_req_v;
    logic [2*AW-1:0]   wr_req_addr;
    logic [2*DW-1:0]   wr_req_data;
    logic [1:0]        wr_req_rdy;
    logic [1:0]        rd_req_v;
    logic [2*AW-1:0]   rd_req_addr;
    logic [1:0]        rd_req_rdy;
    logic              rd_rsp_v;
    logic              rd_rsp_id;
    logic [DW-1:0]     rd_rsp_data;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_re;
    logic [AW-1:0]     mem_raddr;
    logic [DW-1:0]     mem_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // init watch results
    int w_we, w_bad, w_gaps, w_rdy, w_done_bad, w_to;

    logic [DW-1:0] rf [0:2047] = '{default: 14'h3FFF};

    always #5 rclk = ~rclk;

    always @(posedge rclk) begin
        if (mem_we) rf[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= rf[mem_raddr];
    end

    hqm_rf_2048x14_arb_init #(
        .DEPTH    (2048),
        .AW       (AW),
        .DW       (DW),
        .INIT_VAL ('0)
    ) dut (
        .rclk        (rclk),
        .rclk_rst_n  (rclk_rst_n),
        .cfg_reinit  (cfg_reinit),
        .init_busy   (init_busy),
        .init_done   (init_done),
        .wr_req_v    (wr_req_v),
        .wr_req_addr (wr_req_addr),
        .wr_req_data (wr_req_data),
        .wr_req_rdy  (wr_req_rdy),
        .rd_req_v    (rd_req_v),
        .rd_req_addr (rd_req_addr),
        .rd_req_rdy  (rd_req_rdy),
        .rd_rsp_v    (rd_rsp_v),
        .rd_rsp_id   (rd_rsp_id),
        .rd_rsp_data (rd_rsp_data),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_re      (mem_re),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge where init_busy
    // is first seen low. Valids are dropped at that point.
    task automatic watch_init(input logic exp_done);
        bit finished = 0;
        w_we = 0; w_bad = 0; w_gaps = 0; w_rdy = 0; w_done_bad = 0; w_to = 0;
        for (int i = 0; i < 3000 && !finished; i++) begin
            @(negedge rclk);
            if (init_busy && ((wr_req_rdy | rd_req_rdy) != 2'b00)) w_rdy++;
            if (init_busy && (init_done != exp_done)) w_done_bad++;
            if (mem_we) begin
                if (mem_waddr != AW'(w_we) || mem_wdata != '0) w_bad++;
                w_we++;
            end else if (w_we > 0) begin
                w_gaps++;
            end
            if (!init_busy) finished = 1;
        end
        if (!finished) w_to = 1;
        wr_req_v = 2'b00;
        rd_req_v = 2'b00;
    endtask

    task automatic check_init(input string p);
        check({p, "_timeout"},   w_to, 0);
        check({p, "_we_count"},  w_we, 2048);
        check({p, "_addr_data"}, w_bad, 0);
        check({p, "_gaps"},      w_gaps, 0);
        check({p, "_rdy_zero"},  w_rdy, 0);
        check({p, "_done_hold"}, w_done_bad, 0);
        check({p, "_done"},      init_done, 1);
        check({p, "_busy"},      init_busy, 0);
        @(negedge rclk);
        check({p, "_we_off"},    mem_we, 0);
    endtask

    task automatic do_write(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        wr_req_v = 2'b00;
        wr_req_v[id] = 1'b1;
        wr_req_addr[id*AW +: AW] = a;
        wr_req_data[id*DW +: DW] = d;
        #1 check({tag, "_rdy"}, wr_req_rdy, 32'(1 << id));
        @(negedge rclk);
        wr_req_v = 2'b00;
        check({tag, "_we"},    mem_we, 1);
        check({tag, "_waddr"}, mem_waddr, a);
        check({tag, "_wdata"}, mem_wdata, d);
    endtask

    task automatic do_read(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        rd_req_v = 2'b00;
        rd_req_v[id] = 1'b1;
        rd_req_addr[id*AW +: AW] = a;
        #1 check({tag, "_rdy"}, rd_req_rdy, 32'(1 << id));
        @(negedge rclk);
        rd_req_v = 2'b00;
        check({tag, "_re"},     mem_re, 1);
        check({tag, "_raddr"},  mem_raddr, a);
        check({tag, "_early"},  rd_rsp_v, 0);
        @(negedge rclk);
        check({tag, "_rsp_v"},  rd_rsp_v, 1);
        check({tag, "_rsp_id"}, rd_rsp_id, id);
        check({tag, "_data"},   rd_rsp_data, d);
    endtask

    initial begin
        rclk_rst_n  = 1'b0;
        cfg_reinit  = 1'b0;
        wr_req_v    = 2'b11;
        rd_req_v    = 2'b11;
        wr_req_addr = '0;
        wr_req_data = '0;
        rd_req_addr = '0;

        // reset state
        repeat (3) @(negedge rclk);
        check("rst_busy",  init_busy, 1);
        check("rst_done",  init_done, 0);
        check("rst_we",    mem_we, 0);
        check("rst_waddr", mem_waddr, 0);
        check("rst_re",    mem_re, 0);
        check("rst_rsp_v", rd_rsp_v, 0);
        check("rst_rdy",   {wr_req_rdy, rd_req_rdy}, 0);
        wr_req_v = 2'b00;
        rd_req_v = 2'b00;

        // 1: power-on init
        rclk_rst_n = 1'b1;
        watch_init(1'b0);
        check_init("init1");
        do_read(0, 11'h123, 14'h0000, "t1_rd");

        // 2: write then read through the RF
        do_write(0, 11'h005, 14'h1ABC, "t2_wr");
        do_read(1, 11'h005, 14'h1ABC, "t2_rd");

        // 3: both readers valid for 4 cycles (rd ptr is at 0)
        do_write(1, 11'h010, 14'h0333, "t3_wr");
        rd_req_addr = {11'h010, 11'h005};
        for (int k = 0; k < 6; k++) begin
            if (k >= 2) begin
                check("t3_rsp_v",  rd_rsp_v, 1);
                check("t3_rsp_id", rd_rsp_id, (k - 2) % 2);
                check("t3_data",   rd_rsp_data, ((k - 2) % 2) ? 14'h0333 : 14'h1ABC);
            end else begin
                check("t3_rsp_idle", rd_rsp_v, 0);
            end
            rd_req_v = (k < 4) ? 2'b11 : 2'b00;
            #1;
            if (k < 4) check("t3_grant", rd_req_rdy, (k % 2) ? 2'b10 : 2'b01);
            @(negedge rclk);
        end

        // 4: same-cycle write/read collision -> forwarded data
        wr_req_v = 2'b10;
        wr_req_addr[2*AW-1:AW] = 11'h7FF;
        wr_req_data[2*DW-1:DW] = 14'h2222;
        rd_req_v = 2'b01;
        rd_req_addr[AW-1:0] = 11'h7FF;
        #1 check("t4_rdy", {wr_req_rdy, rd_req_rdy}, 4'b1001);
        @(negedge rclk);
        wr_req_v = 2'b00;
        rd_req_v = 2'b00;
        check("t4_we_re", {mem_we, mem_re}, 2'b11);
        @(negedge rclk);
        check("t4_rsp_v", rd_rsp_v, 1);
        check("t4_rsp_id", rd_rsp_id, 0);
        check("t4_bypass", rd_rsp_data, 14'h2222);
        do_read(1, 11'h7FF, 14'h2222, "t4_rf");

        // write arbiter: both valid (wr ptr at 0 after wr1 grant)
        wr_req_v    = 2'b11;
        wr_req_addr = {11'h021, 11'h020};
        wr_req_data = {14'h0BBB, 14'h0AAA};
        #1 check("wa_g0", wr_req_rdy, 2'b01);
        @(negedge rclk);
        #1 check("wa_g1", wr_req_rdy, 2'b10);
        check("wa_addr0", mem_waddr, 11'h020);
        @(negedge rclk);
        wr_req_v = 2'b00;
        check("wa_addr1", {mem_waddr, mem_wdata}, {11'h021, 14'h0BBB});
        do_read(0, 11'h020, 14'h0AAA, "wa_rd");

        // 5: reinit with a read in flight
        rd_req_v = 2'b10;
        rd_req_addr[2*AW-1:AW] = 11'h005;
        #1 check("t5_rdy", rd_req_rdy, 2'b10);
        @(negedge rclk);
        cfg_reinit = 1'b1;
        wr_req_v   = 2'b11;
        rd_req_v   = 2'b11;
        #1 check("t5_reinit_rdy", {wr_req_rdy, rd_req_rdy}, 0);
        @(negedge rclk);
        cfg_reinit = 1'b0;
        check("t5_rsp_v",  rd_rsp_v, 1);
        check("t5_rsp_id", rd_rsp_id, 1);
        check("t5_data",   rd_rsp_data, 14'h1ABC);
        watch_init(1'b1);
        check_init("init2");
        do_read(1, 11'h005, 14'h0000, "t5_rd5");
        do_read(0, 11'h7FF, 14'h0000, "t5_rd7ff");

        // reset drops an in-flight read
        rd_req_v = 2'b01;
        rd_req_addr[AW-1:0] = 11'h005;
        #1 check("rr_rdy", rd_req_rdy, 2'b01);
        @(negedge rclk);
        rd_req_v   = 2'b00;
        rclk_rst_n = 1'b0;
        #1 check("rr_re", mem_re, 0);
        @(negedge rclk);
        check("rr_rsp_v", rd_rsp_v, 0);
        rclk_rst_n = 1'b1;

        // 6: reset at init counter 0x300
        begin
            bit hit = 0;
            for (int i = 0; i < 3000 && !hit; i++) begin
                @(negedge rclk);
                if (mem_we && mem_waddr == 11'h300) hit = 1;
            end
            check("t6_reach_300", hit, 1);
        end
        rclk_rst_n = 1'b0;
        #1;
        check("t6_we",    mem_we, 0);
        check("t6_waddr", mem_waddr, 0);
        check("t6_busy",  init_busy, 1);
        check("t6_done",  init_done, 0);
        check("t6_rsp",   {rd_rsp_v, rd_rsp_id, rd_rsp_data}, 0);
        @(negedge rclk);
        rclk_rst_n = 1'b1;
        watch_init(1'b0);
        check_init("init3");
        do_read(0, 11'h021, 14'h0000, "t6_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
